// File: rtl/index_reader_pkg.sv
// Shared definitions for the index reader: frame defaults, FSM encoding
// and the read-credit helper used to keep the output queue from overflowing.
package index_reader_pkg;

  localparam int DEF_NUM_INDEX = 81;
  localparam int DEF_IDX_W     = 7;

  // Output queue depth: output register plus one skid register.
  localparam int QUEUE_DEPTH   = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BUF = 2'd1,
    ST_STREAM   = 2'd2,
    ST_DONE     = 2'd3
  } rd_state_e;

  // A new read may go out only if the entries that remain after this
  // cycle's drain, plus the read already in flight, leave a free slot.
  function automatic logic has_room(input logic [1:0] occ_after_drain,
                                    input logic       inflight);
    return (3'(occ_after_drain) + 3'(inflight)) < 3'(QUEUE_DEPTH);
  endfunction

endpackage

// File: rtl/index_reader_if.sv
// Bundle of the buffer-read and downstream-index signals of index_reader.
// The master modport is the reader itself; slave is its environment.
interface index_reader_if #(
  parameter int IDX_W = index_reader_pkg::DEF_IDX_W
) ();

  logic             start;
  logic             index_buffer_ready;
  logic             rd_en;
  logic [IDX_W-1:0] rd_addr;
  logic [IDX_W-1:0] rd_data;
  logic [IDX_W-1:0] index_out;
  logic             index_valid;
  logic             index_ready;
  logic             busy;
  logic             done;
  logic             range_err;

  modport master (
    input  start, index_buffer_ready, rd_data, index_ready,
    output rd_en, rd_addr, index_out, index_valid, busy, done, range_err
  );

  modport slave (
    output start, index_buffer_ready, rd_data, index_ready,
    input  rd_en, rd_addr, index_out, index_valid, busy, done, range_err
  );

endinterface

// File: rtl/index_reader_skid_fifo.sv
// Two-entry output queue (output register + skid register) for the index
// stream. A write arriving while the output register is held by
// backpressure lands in the skid register, so no read return is lost.
module index_skid_fifo #(
  parameter int W = index_reader_pkg::DEF_IDX_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_in_valid,
  input  logic [W-1:0] i_in_data,
  input  logic         i_out_ready,
  output logic         o_out_valid,
  output logic [W-1:0] o_out_data,
  output logic [1:0]   o_count
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;
  logic         w_out_free;

  // The output register can take new data when empty or draining this cycle.
  assign w_out_free = !r_out_valid || i_out_ready;

  // Queue update: refill the output register from skid first, then from input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= i_in_valid;
        if (i_in_valid) r_skid_data <= i_in_data;
      end else begin
        r_out_valid <= i_in_valid;
        if (i_in_valid) r_out_data <= i_in_data;
      end
    end else if (i_in_valid) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_in_data;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_count     = {1'b0, r_out_valid} + {1'b0, r_skid_valid};

endmodule

// File: rtl/index_reader.sv
// Index reader: on start, waits for the upstream buffer to fill, then reads
// NUM_INDEX indexes at ascending addresses and streams them downstream with
// valid/ready flow control through a 2-entry queue.
// Optional feature macro: INDEX_READER_RANGE_CHECK_EN enables the sticky
// out-of-range flag on range_err (tied low otherwise).
module index_reader
  import index_reader_pkg::*;
#(
  parameter int NUM_INDEX = DEF_NUM_INDEX,
  parameter int IDX_W     = DEF_IDX_W
) (
  input  logic           clk,
  input  logic           reset,
  index_reader_if.master bus
);

  localparam int CNT_W = $clog2(NUM_INDEX + 1);

  rd_state_e        r_state;
  rd_state_e        w_state_next;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_xfer_cnt;
  logic [IDX_W-1:0] r_rd_addr;
  logic             r_inflight;

  logic             w_rd_en;
  logic             w_xfer;
  logic             w_last_xfer;
  logic             w_start_acc;
  logic [1:0]       w_fifo_cnt;
  logic [1:0]       w_occ_after;
  logic             w_out_valid;
  logic [IDX_W-1:0] w_out_data;

  assign w_start_acc = (r_state == ST_IDLE) && bus.start;
  assign w_xfer      = w_out_valid && bus.index_ready;
  assign w_last_xfer = w_xfer && (r_state == ST_STREAM) &&
                       (r_xfer_cnt == CNT_W'(NUM_INDEX - 1));
  assign w_occ_after = w_fifo_cnt - {1'b0, w_xfer};
  assign w_rd_en     = (r_state == ST_STREAM) &&
                       (r_issue_cnt < CNT_W'(NUM_INDEX)) &&
                       has_room(w_occ_after, r_inflight);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (bus.start) w_state_next = ST_WAIT_BUF;
      ST_WAIT_BUF: if (bus.index_buffer_ready) w_state_next = ST_STREAM;
      ST_STREAM:   if (w_last_xfer) w_state_next = ST_DONE;
      ST_DONE:     w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // Read-issue and transfer counters; the last issued address is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_issue_cnt <= '0;
      r_xfer_cnt  <= '0;
      r_rd_addr   <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_start_acc) begin
        r_issue_cnt <= '0;
        r_xfer_cnt  <= '0;
      end else begin
        if (w_rd_en) begin
          r_issue_cnt <= r_issue_cnt + CNT_W'(1);
          r_rd_addr   <= IDX_W'(r_issue_cnt);
        end
        if (w_xfer && (r_state == ST_STREAM)) r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
      end
    end
  end

  index_skid_fifo #(.W(IDX_W)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (r_inflight),
    .i_in_data   (bus.rd_data),
    .i_out_ready (bus.index_ready),
    .o_out_valid (w_out_valid),
    .o_out_data  (w_out_data),
    .o_count     (w_fifo_cnt)
  );

`ifdef INDEX_READER_RANGE_CHECK_EN
  logic r_range_err;

  // Sticky flag for any forwarded index outside 0..NUM_INDEX-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          r_range_err <= 1'b0;
    else if (w_start_acc)                               r_range_err <= 1'b0;
    else if (w_xfer && (int'(w_out_data) >= NUM_INDEX)) r_range_err <= 1'b1;
  end

  assign bus.range_err = r_range_err;
`else
  assign bus.range_err = 1'b0;
`endif

  assign bus.rd_en       = w_rd_en;
  assign bus.rd_addr     = w_rd_en ? IDX_W'(r_issue_cnt) : r_rd_addr;
  assign bus.index_out   = w_out_data;
  assign bus.index_valid = w_out_valid;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_index_reader.sv
// Scoreboard bench for index_reader: the stimulus side pushes each frame's
// expected indexes into a queue; a negedge monitor pops and compares on
// every transfer and also tracks read addresses, done and range_err.
module tb_index_reader;
  import index_reader_pkg::*;

  localparam int N = 81;
  localparam int W = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  index_reader_if #(.IDX_W(W)) bus ();

  index_reader #(.NUM_INDEX(N), .IDX_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         check_cnt = 0;
  int         pass_cnt  = 0;
  logic [W-1:0] mem [N];
  int         exp_q [$];
  int         exp_addr = 0;
  int         xfer_in_frame = 0;
  int         done_cnt = 0;
  int         cycle_cnt = 0;
  int         first_xfer = 0;
  int         last_xfer = 0;
  bit         expect_done = 0;
  bit         exp_range = 0;
  bit         prev_stall = 0;
  int         prev_out = 0;
  int         ready_mode = 0;
  bit         pend = 0;
  logic [W-1:0] pend_addr = '0;

  task automatic chk(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_en"},       bus.rd_en,       0);
    chk({tag, "_rd_addr"},     bus.rd_addr,     0);
    chk({tag, "_index_out"},   bus.index_out,   0);
    chk({tag, "_index_valid"}, bus.index_valid, 0);
    chk({tag, "_busy"},        bus.busy,        0);
    chk({tag, "_done"},        bus.done,        0);
    chk({tag, "_range_err"},   bus.range_err,   0);
  endtask

  // Issue a start in IDLE and queue the frame's expected contents.
  task automatic start_frame;
    for (int i = 0; i < N; i++) exp_q.push_back(int'(mem[i]));
    exp_addr      = 0;
    xfer_in_frame = 0;
    bus.start     = 1'b1;
    tick();
    exp_range     = 1'b0;
    bus.start     = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int budget, input string name);
    int n  = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, done_cnt - d0, 1);
    repeat (3) tick();
    chk({name, "_single_done"}, done_cnt - d0, 1);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_idle_busy"}, bus.busy, 0);
  endtask

  task automatic wait_xfers(input int count, input int budget, input string name);
    int n = 0;
    while (xfer_in_frame < count && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_reached_xfers"}, int'(xfer_in_frame >= count), 1);
  endtask

  // Buffer model: data for a read seen in cycle T is presented in cycle T+1.
  initial forever begin
    @(negedge clk);
    pend      = bus.rd_en && !reset;
    pend_addr = bus.rd_addr;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (pend) bus.rd_data = mem[pend_addr];
  end

  // Downstream ready: always high, or the 1,0,0,1 backpressure pattern.
  initial begin
    int ph = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) begin
        bus.index_ready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        bus.index_ready = 1'b1;
      end
    end
  end

  // Monitor and scoreboard.
  always @(negedge clk) begin : monitor
    int e;
    cycle_cnt++;
    if (!reset) begin
      if (bus.rd_en) begin
        chk("rd_addr", bus.rd_addr, exp_addr);
        exp_addr++;
      end
      if (bus.done) begin
        chk("done_expected", expect_done, 1);
        done_cnt++;
        expect_done = 1'b0;
      end else if (expect_done) begin
        chk("done_after_last", bus.done, 1);
        expect_done = 1'b0;
      end
      chk("range_err", bus.range_err, exp_range);
      if (prev_stall && bus.index_valid) chk("stall_stable", bus.index_out, prev_out);
      if (bus.index_valid && bus.index_ready) begin
        if (exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL unexpected_xfer: actual index_out=%0d required no transfer (t=%0t)",
                   bus.index_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("index_out", bus.index_out, e);
          $display("xfer %0d value=%0d expected=%0d", xfer_in_frame, bus.index_out, e);
          if (xfer_in_frame == 0) first_xfer = cycle_cnt;
          xfer_in_frame++;
`ifdef INDEX_READER_RANGE_CHECK_EN
          if (e >= N) exp_range = 1'b1;
`endif
          if (exp_q.size() == 0) begin
            expect_done = 1'b1;
            last_xfer   = cycle_cnt;
          end
        end
      end
      prev_stall = bus.index_valid && !bus.index_ready;
      prev_out   = int'(bus.index_out);
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit no_rd;
    reset                  = 1'b1;
    bus.start              = 1'b0;
    bus.index_buffer_ready = 1'b0;
    bus.index_ready        = 1'b1;
    bus.rd_data            = '0;
    for (int i = 0; i < N; i++) mem[i] = W'(i);

    repeat (2) tick();
    chk_reset_vals("por");
    reset = 1'b0;
    tick();

    // Full-rate frame.
    bus.index_buffer_ready = 1'b1;
    start_frame();
    wait_done(400, "t1");
    chk("t1_consecutive", last_xfer - first_xfer, N - 1);

    // Buffer not ready for 20 cycles.
    bus.index_buffer_ready = 1'b0;
    start_frame();
    no_rd = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.rd_en) no_rd = 1'b0;
    end
    chk("t2_no_rd_en_while_waiting", no_rd, 1);
    chk("t2_busy_while_waiting", bus.busy, 1);
    tick();
    bus.index_buffer_ready = 1'b1;
    wait_done(400, "t2");

    // Backpressure pattern.
    ready_mode = 1;
    start_frame();
    wait_done(800, "t3");
    ready_mode = 0;

    // Reset mid-frame, then a fresh frame from address 0.
    start_frame();
    wait_xfers(40, 400, "t4");
    tick();
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick();
    exp_q.delete();
    expect_done = 1'b0;
    exp_range   = 1'b0;
    reset       = 1'b0;
    tick();
    start_frame();
    wait_done(400, "t4");

    // Out-of-range entry at address 5.
    mem[5] = W'(100);
    start_frame();
    wait_done(400, "t5");
`ifdef INDEX_READER_RANGE_CHECK_EN
    chk("t5_range_err_sticky", bus.range_err, 1);
`else
    chk("t5_range_err_tied_low", bus.range_err, 0);
`endif
    mem[5] = W'(5);
    start_frame();
    chk("t5_range_err_cleared_by_start", bus.range_err, 0);
    wait_done(400, "t5b");

    // start pulsed mid-stream must be ignored.
    start_frame();
    wait_xfers(10, 400, "t6");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(400, "t6");
    repeat (10) tick();
    chk("t6_no_restart_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/index_reader.md
INDEX_READER -- requirements
Module: index_reader

Interface
REQ-001 SHALL have parameter NUM_INDEX, default 81, number of indexes per frame.
REQ-002 SHALL have parameter IDX_W, default 7, width of one index and of the buffer address.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to stream one frame.
REQ-006 SHALL have port index_buffer_ready, input, 1, high when the upstream index buffer holds NUM_INDEX entries.
REQ-007 SHALL have port rd_en, output, 1, buffer read strobe.
REQ-008 SHALL have port rd_addr, output, IDX_W, buffer read address.
REQ-009 SHALL have port rd_data, input, IDX_W, buffer read data, valid exactly one cycle after rd_en.
REQ-010 SHALL have port index_out, output, IDX_W, index presented downstream.
REQ-011 SHALL have port index_valid, output, 1, index_out holds a valid index.
REQ-012 SHALL have port index_ready, input, 1, downstream accepts index_out.
REQ-013 SHALL have port busy, output, 1, a frame is in progress.
REQ-014 SHALL have port done, output, 1, single-cycle pulse after the last index is accepted.
REQ-015 SHALL have port range_err, output, 1, sticky out-of-range index flag.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT_BUF -> STREAM -> DONE -> IDLE.
REQ-017 SHALL move IDLE->WAIT_BUF on start; start is ignored outside IDLE.
REQ-018 SHALL move WAIT_BUF->STREAM in the cycle index_buffer_ready is sampled high; it SHALL stay in WAIT_BUF indefinitely otherwise.
REQ-019 SHALL issue reads at addresses 0..NUM_INDEX-1 in ascending order, one per rd_en, with no address repeated or skipped.
REQ-020 SHALL keep a 2-entry output queue (output register plus skid register) and assert rd_en only when occupied entries plus in-flight reads are fewer than 2.
REQ-021 SHALL sustain one index per cycle while index_ready is held high, with first index_valid 2 cycles after entering STREAM.
REQ-022 SHALL transfer an index only on a cycle with index_valid and index_ready both high; index_out SHALL stay stable while index_valid is high and index_ready is low.
REQ-023 SHALL never drop a read return under backpressure; an arriving rd_data is written to the skid register when the output register is occupied and not draining.
REQ-024 SHALL move STREAM->DONE on the transfer of index NUM_INDEX-1; DONE lasts one cycle with done=1, then IDLE.
REQ-025 SHALL hold busy high in WAIT_BUF, STREAM and DONE, low in IDLE.
REQ-026 SHALL keep rd_addr at its last issued value when rd_en is low.
REQ-027 SHALL ignore index_ready while index_valid is low.
REQ-028 SHALL let start be accepted in the cycle following DONE.

Reset
REQ-029 SHALL, on reset asserted, immediately set state IDLE, rd_en=0, rd_addr=0, index_out=0, index_valid=0, busy=0, done=0 and range_err=0, and clear both queue entries and the in-flight count.
REQ-030 SHALL abort a frame on reset asserted mid-stream, discarding in-flight read data; the next frame restarts at address 0.

Configuration
REQ-031 SHALL, with INDEX_READER_RANGE_CHECK_EN defined, set range_err sticky when a transferred index is >= NUM_INDEX; the index is still forwarded unchanged, and range_err is cleared only by reset or by start accepted in IDLE.
REQ-032 SHALL, without INDEX_READER_RANGE_CHECK_EN, keep the range_err port and tie it to 0.

Structure
REQ-033 SHALL take the FSM state encoding and the NUM_INDEX/IDX_W defaults from the shared NPU package.
REQ-034 SHALL place the 2-entry output queue in sub-module index_skid_fifo.

Verification
REQ-035 SHALL verify this sequence: start with index_buffer_ready=1, index_ready=1, buffer content i -> 81 transfers of values 0..80 on consecutive cycles, done=1 one cycle after the last transfer.
REQ-036 SHALL verify this sequence: start with index_buffer_ready=0 for 20 cycles, then raised -> rd_en stays 0 for those 20 cycles, then streaming starts.
REQ-037 SHALL verify this sequence: index_ready toggles 1,0,0,1 repeatedly -> all 81 values arrive in order with none lost or duplicated, and index_out is stable while stalled.
REQ-038 SHALL verify this sequence: reset pulse after 40 transfers, then start -> outputs return to their reset values and the new frame begins at rd_addr=0.
REQ-039 SHALL verify this sequence: with INDEX_READER_RANGE_CHECK_EN defined and buffer entry 5 = 100 -> range_err rises on the transfer of that entry and stays 1 until the next start.
REQ-040 SHALL verify this sequence: start pulsed during STREAM -> no effect; exactly 81 transfers and one done pulse.
